// File: rtl/job_q_2_1_sweep.sv
// Sweep stage for job_q_2_1: walks A..D through 0..15, samples OutputY per vector and builds the truth table.
// Optional comparison against ExpectedTable is built when JOB_Q_SWEEP_COMPARE_EN is defined.
module job_q_2_1_sweep #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Start,
    input  logic [15:0] ExpectedTable,
    input  logic        OutputY,
    output logic        InputA,
    output logic        InputB,
    output logic        InputC,
    output logic        InputD,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] TruthTable,
    output logic [4:0]  MismatchCount,
    output logic        Pass,
    output logic [1:0]  DebugState
);

    // Handshake: Start is a level request with no ready; it is accepted only on a
    // rising edge where the FSM is IDLE, and ignored (never queued) otherwise.

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [3:0]    index;
    logic [CW-1:0] settleCnt;
    logic [3:0]    stim;

    assign {InputA, InputB, InputC, InputD} = stim;
    assign DebugState = state;

`ifdef JOB_Q_SWEEP_COMPARE_EN
    logic [15:0] expLatched;
    logic [4:0]  mismatchReg;
    logic        passReg;
    logic        miss;

    assign miss          = OutputY ^ expLatched[index];
    assign MismatchCount = mismatchReg;
    assign Pass          = passReg;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            expLatched  <= '0;
            mismatchReg <= '0;
            passReg     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    expLatched  <= ExpectedTable;
                    mismatchReg <= '0;
                    passReg     <= 1'b0;
                end
                SAMPLE: begin
                    if (miss)
                        mismatchReg <= mismatchReg + 5'd1;
                    // Final vector: fold this sample's result in so Pass is valid alongside Done
                    if (index == 4'd15)
                        passReg <= (mismatchReg == 5'd0) && !miss;
                end
                default: ;
            endcase
        end
    end
`else
    logic unusedExpected;
    assign unusedExpected = ^ExpectedTable;
    assign MismatchCount  = '0;
    assign Pass           = 1'b0;
`endif

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state      <= IDLE;
            index      <= '0;
            settleCnt  <= '0;
            stim       <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            TruthTable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        TruthTable <= '0;
                        index      <= '0;
                        settleCnt  <= '0;
                        stim       <= '0;
                        Busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settleCnt == LAST_SETTLE)
                        state <= SAMPLE;
                    else
                        settleCnt <= settleCnt + 1'b1;
                end
                SAMPLE: begin
                    TruthTable[index] <= OutputY;
                    if (index == 4'd15) begin
                        stim  <= '0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Stimulus changes only here, so each code is held through SETTLE and SAMPLE
                        index     <= index + 4'd1;
                        stim      <= index + 4'd1;
                        settleCnt <= '0;
                        state     <= SETTLE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_job_q_2_1_sweep.sv
// Bench for job_q_2_1_sweep: a table-driven model of job_q_2_1 answers the stimulus, plus random tables
// and hand-written reset / restart sequences.
module tb_job_q_2_1_sweep;

    localparam int SETTLE = 4;
    localparam int VEC_CYCLES = SETTLE + 1;
    localparam int DONE_CYCLE = 16 * VEC_CYCLES + 1;
`ifdef JOB_Q_SWEEP_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] ExpectedTable = '0;
    logic        OutputY;
    logic        InputA, InputB, InputC, InputD;
    logic        Busy, Done, Pass;
    logic [15:0] TruthTable;
    logic [4:0]  MismatchCount;
    logic [1:0]  DebugState;

    logic [15:0] yModel = '0;
    int          nVectors = 0;
    int          nMiscompares = 0;
    logic [15:0] expQ[$];

    // Behavioural job_q_2_1: output is a lookup of the current input code
    assign OutputY = yModel[{InputA, InputB, InputC, InputD}];

    always #5 Clock = ~Clock;

    job_q_2_1_sweep #(.SETTLE_CYCLES(SETTLE)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .ExpectedTable(ExpectedTable),
        .OutputY(OutputY), .InputA(InputA), .InputB(InputB), .InputC(InputC), .InputD(InputD),
        .Busy(Busy), .Done(Done), .TruthTable(TruthTable), .MismatchCount(MismatchCount),
        .Pass(Pass), .DebugState(DebugState)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nVectors++;
        if (act !== want) begin
            nMiscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Called at a negedge with the DUT idle. Runs one sweep, checks every cycle against the
    // timing rules, and ends at the negedge of cycle DONE_CYCLE+1.
    task automatic run_sweep(input logic [15:0] yT, input logic [15:0] eT, input int mis,
                             input bit hold, input bit poke);
        int wantStim;
        bit wantBusy, wantDone;
        logic [15:0] wantTable;
        yModel = yT;
        ExpectedTable = eT;
        Start = 1'b1;
        expQ.push_back(yT);
        check("idle_before_start", {Busy, Done, DebugState}, {1'b0, 1'b0, 2'd0});
        for (int c = 1; c <= DONE_CYCLE + 1; c++) begin
            @(negedge Clock);
            if (c <= DONE_CYCLE - 1) begin
                wantStim = (c - 1) / VEC_CYCLES;
                wantBusy = 1'b1;
                wantDone = 1'b0;
            end else begin
                wantStim = 0;
                wantBusy = 1'b0;
                wantDone = (c == DONE_CYCLE);
            end
            check($sformatf("cycle_%0d", c), {InputA, InputB, InputC, InputD, Busy, Done},
                  {wantStim[3:0], wantBusy, wantDone});
            if (c == 1) ExpectedTable = ~eT;
            if (hold) Start = 1'b1;
            else Start = poke && (c == 3 * VEC_CYCLES + 2 || c == 15 * VEC_CYCLES + 1);
        end
        wantTable = expQ.pop_front();
        check("truth_table", TruthTable, wantTable);
        check("mismatch_count", MismatchCount, CMP ? mis : 0);
        check("pass", Pass, CMP && (mis == 0));
    endtask

    typedef struct {
        logic [15:0] yTable;
        logic [15:0] expTable;
        int          wantMis;
    } vec_t;

    vec_t vecs[6];
    logic [15:0] rY, rE;
    int doneSeen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'hF888, 16'hF888, 0};
        vecs[1] = '{16'hF888, 16'hF889, 1};
        vecs[2] = '{16'hF888, 16'h0777, 16};
        vecs[3] = '{16'h0000, 16'h0000, 0};
        vecs[4] = '{16'hFFFF, 16'h0000, 16};
        vecs[5] = '{16'hA5A5, 16'h25A4, 2};

        // Reset with Start high: nothing moves
        Start = 1'b1;
        yModel = 16'hF888;
        repeat (3) begin
            @(negedge Clock);
            check("reset_outputs", {InputA, InputB, InputC, InputD, Busy, Done, TruthTable,
                                    MismatchCount, Pass, DebugState}, 32'd0);
        end
        Start = 1'b0;
        ResetN = 1'b1;
        @(negedge Clock);
        check("post_reset_idle", {InputA, InputB, InputC, InputD, Busy, DebugState}, 32'd0);

        for (int i = 0; i < 6; i++)
            run_sweep(vecs[i].yTable, vecs[i].expTable, vecs[i].wantMis, 1'b0, 1'b0);

        // Start pulses while busy are ignored
        run_sweep(16'hF888, 16'hF888, 0, 1'b0, 1'b1);

        // Start held high: second sweep accepted in the first idle cycle
        run_sweep(16'hF888, 16'hF889, 1, 1'b1, 1'b0);
        check("held_start_idle", DebugState, 2'd0);
        run_sweep(16'hF888, 16'hF888, 0, 1'b0, 1'b0);

        // Reset during vector 5 SETTLE
        yModel = 16'hF888;
        ExpectedTable = 16'hF888;
        Start = 1'b1;
        for (int c = 1; c <= 5 * VEC_CYCLES + 2; c++) begin
            @(negedge Clock);
            Start = 1'b0;
        end
        check("mid_sweep_vector", {InputA, InputB, InputC, InputD, Busy}, {4'd5, 1'b1});
        ResetN = 1'b0;
        #1;
        check("mid_reset_outputs", {InputA, InputB, InputC, InputD, Busy, Done, TruthTable,
                                    MismatchCount, Pass, DebugState}, 32'd0);
        repeat (2) @(negedge Clock);
        ResetN = 1'b1;
        doneSeen = 0;
        for (int c = 0; c < DONE_CYCLE + 5; c++) begin
            @(negedge Clock);
            if (Done || Busy) doneSeen++;
        end
        check("no_done_after_reset", doneSeen, 0);
        run_sweep(16'hF888, 16'hF888, 0, 1'b0, 1'b0);

        // Random tables against a popcount model
        for (int r = 0; r < 6; r++) begin
            rY = 16'($urandom_range(0, 65535));
            rE = (r % 2 == 1) ? rY : (rY ^ 16'($urandom_range(0, 65535)));
            run_sweep(rY, rE, $countones(rY ^ rE), 1'b0, r == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
